// File: rtl/mandelbrot_iter_ctrl.sv
// Escape-time sequencer for one pixel: latches c, clears z and feeds z back
// through an external combinational Mandelbrot ALU once per clock until escape or limit.
module mandelbrot_iter_ctrl #(
    parameter int WIDTH  = 8,
    parameter int ITER_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_cr,
    input  logic [WIDTH-1:0]  in_ci,
    input  logic [ITER_W-1:0] max_iter,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ITER_W-1:0] out_iter,
    output logic              out_escaped,
    output logic [WIDTH-1:0]  alu_cr,
    output logic [WIDTH-1:0]  alu_ci,
    output logic [WIDTH-1:0]  alu_zr,
    output logic [WIDTH-1:0]  alu_zi,
    input  logic [WIDTH-1:0]  alu_out_zr,
    input  logic [WIDTH-1:0]  alu_out_zi,
    input  logic              alu_size,
    input  logic              alu_overflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [ITER_W-1:0] CNT_ONE = {{(ITER_W-1){1'b0}}, 1'b1};

    state_t            state_q;
    logic [WIDTH-1:0]  cr_q;
    logic [WIDTH-1:0]  ci_q;
    logic [WIDTH-1:0]  zr_q;
    logic [WIDTH-1:0]  zi_q;
    logic [ITER_W-1:0] cnt_q;
    logic [ITER_W-1:0] max_q;
    logic [ITER_W-1:0] iter_q;
    logic              esc_q;

    // Pixel sequencer: accept, iterate, present result; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cr_q    <= '0;
            ci_q    <= '0;
            zr_q    <= '0;
            zi_q    <= '0;
            cnt_q   <= '0;
            max_q   <= '0;
            iter_q  <= '0;
            esc_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        cr_q  <= in_cr;
                        ci_q  <= in_ci;
                        max_q <= max_iter;
                        zr_q  <= '0;
                        zi_q  <= '0;
                        cnt_q <= '0;
                        if (max_iter == '0) begin
                            state_q <= S_DONE;
                            iter_q  <= '0;
                            esc_q   <= 1'b0;
                        end else begin
                            state_q <= S_ITER;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ITER: begin
                    // Escape outranks the limit; z is frozen at the escaping value.
                    if (alu_size || alu_overflow) begin
                        state_q <= S_DONE;
                        iter_q  <= cnt_q;
                        esc_q   <= 1'b1;
                    end else if ((cnt_q + CNT_ONE) == max_q) begin
                        state_q <= S_DONE;
                        iter_q  <= max_q;
                        esc_q   <= 1'b0;
                    end else begin
                        zr_q  <= alu_out_zr;
                        zi_q  <= alu_out_zi;
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign out_iter    = iter_q;
    assign out_escaped = esc_q;
    assign alu_cr      = cr_q;
    assign alu_ci      = ci_q;
    assign alu_zr      = zr_q;
    assign alu_zi      = zi_q;

endmodule

// File: tb/tb_mandelbrot_iter_ctrl.sv
// Bench for mandelbrot_iter_ctrl: a behavioural ALU closes the loop, and a
// per-pixel escape-time model predicts z trajectory, result and latency.
module tb_mandelbrot_iter_ctrl;

    localparam int W  = 8;
    localparam int IW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_cr;
    logic [W-1:0]  in_ci;
    logic [IW-1:0] max_iter;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_iter;
    logic          out_escaped;
    logic [W-1:0]  alu_cr, alu_ci, alu_zr, alu_zi;
    logic [W-1:0]  alu_out_zr, alu_out_zi;
    logic          alu_size, alu_overflow;
    logic [17:0]   alu_res;

    int total = 0;
    int bad   = 0;
    int ezr [0:63];
    int ezi [0:63];

    always #5 clk = ~clk;

    mandelbrot_iter_ctrl #(.WIDTH(W), .ITER_W(IW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_cr(in_cr), .in_ci(in_ci), .max_iter(max_iter),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_iter(out_iter), .out_escaped(out_escaped),
        .alu_cr(alu_cr), .alu_ci(alu_ci), .alu_zr(alu_zr), .alu_zi(alu_zi),
        .alu_out_zr(alu_out_zr), .alu_out_zi(alu_out_zi),
        .alu_size(alu_size), .alu_overflow(alu_overflow)
    );

    // z' = z^2 + c in signed 2.6 fixed point; returns {size, overflow, zr', zi'}
    function automatic logic [17:0] alu_f(logic signed [7:0] zr, logic signed [7:0] zi,
                                          logic signed [7:0] cr, logic signed [7:0] ci);
        int r2, i2, nr, ni;
        logic sz, ov;
        r2 = int'(zr) * int'(zr);
        i2 = int'(zi) * int'(zi);
        nr = ((r2 - i2) >>> 6) + int'(cr);
        ni = ((2 * int'(zr) * int'(zi)) >>> 6) + int'(ci);
        sz = (r2 + i2) > 16384;
        ov = (nr > 127) || (nr < -128) || (ni > 127) || (ni < -128);
        return {sz, ov, nr[7:0], ni[7:0]};
    endfunction

    always_comb begin
        alu_res = alu_f(alu_zr, alu_zi, alu_cr, alu_ci);
    end
    assign alu_size     = alu_res[17];
    assign alu_overflow = alu_res[16];
    assign alu_out_zr   = alu_res[15:8];
    assign alu_out_zi   = alu_res[7:0];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Escape-time reference: walk z_0, z_1, ... and stop on first flag or limit
    task automatic model(input logic [7:0] cr, input logic [7:0] ci, input int mi,
                         output int lat, output int it, output int esc);
        logic [7:0]  zr, zi;
        logic [17:0] r;
        zr = 8'h00; zi = 8'h00;
        lat = 1; it = 0; esc = 0;
        for (int n = 0; n < mi; n++) begin
            ezr[n] = int'(zr);
            ezi[n] = int'(zi);
            r = alu_f(zr, zi, cr, ci);
            if (r[17] || r[16]) begin
                it = n; esc = 1; lat = 2 + n;
                break;
            end
            if (n + 1 == mi) begin
                it = mi; esc = 0; lat = 1 + mi;
                break;
            end
            zr = r[15:8];
            zi = r[7:0];
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_iter", int'(out_iter), 0);
        chk("rst_out_escaped", int'(out_escaped), 0);
        chk("rst_alu_cr", int'(alu_cr), 0);
        chk("rst_alu_ci", int'(alu_ci), 0);
        chk("rst_alu_zr", int'(alu_zr), 0);
        chk("rst_alu_zi", int'(alu_zi), 0);
    endtask

    // Drive one pixel and compare every cycle until the output handshake (or reset at cycle rst_at)
    task automatic run_pixel(input logic [7:0] cr, input logic [7:0] ci, input int mi,
                             input int stall, input int rst_at);
        int lat, it, esc;
        model(cr, ci, mi, lat, it, esc);
        @(negedge clk);
        in_valid = 1'b1; in_cr = cr; in_ci = ci; max_iter = IW'(mi); out_ready = 1'b0;
        chk("accept_in_ready", int'(in_ready), 1);
        @(negedge clk);
        for (int i = 1; i <= lat; i++) begin
            if (i > 1) @(negedge clk);
            if (rst_at != 0 && i == rst_at) begin
                rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                check_reset_vals();
                return;
            end
            chk("out_valid", int'(out_valid), (i == lat) ? 1 : 0);
            chk("busy_in_ready", int'(in_ready), 0);
            if (i < lat) begin
                chk("alu_zr", int'(alu_zr), ezr[i-1] & 255);
                chk("alu_zi", int'(alu_zi), ezi[i-1] & 255);
                chk("alu_cr", int'(alu_cr), int'(cr));
                chk("alu_ci", int'(alu_ci), int'(ci));
            end else begin
                chk("out_iter", int'(out_iter), it);
                chk("out_escaped", int'(out_escaped), esc);
            end
            // Inputs that must be ignored once a pixel is in flight
            in_valid  = 1'($urandom);
            in_cr     = 8'($urandom);
            in_ci     = 8'($urandom);
            max_iter  = 6'($urandom);
            out_ready = (i < lat) ? 1'($urandom) : 1'b0;
        end
        for (int s = 0; s < stall; s++) begin
            out_ready = 1'b0;
            in_valid  = 1'($urandom);
            @(negedge clk);
            chk("stall_out_valid", int'(out_valid), 1);
            chk("stall_in_ready", int'(in_ready), 0);
            chk("stall_out_iter", int'(out_iter), it);
            chk("stall_out_escaped", int'(out_escaped), esc);
            chk("stall_alu_cr", int'(alu_cr), int'(cr));
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("post_hs_out_valid", int'(out_valid), 0);
        chk("post_hs_in_ready", int'(in_ready), 1);
    endtask

    task automatic pin(input logic [7:0] cr, input logic [7:0] ci, input int mi,
                       input int e_lat, input int e_it, input int e_esc);
        int lat, it, esc;
        model(cr, ci, mi, lat, it, esc);
        chk("pin_lat", lat, e_lat);
        chk("pin_iter", it, e_it);
        chk("pin_esc", esc, e_esc);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_cr = 8'h00; in_ci = 8'h00;
        max_iter = 6'd0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals();
        for (int k = 0; k < 4; k++) begin
            out_ready = ~out_ready;
            @(negedge clk);
            chk("idle_in_ready", int'(in_ready), 1);
            chk("idle_out_valid", int'(out_valid), 0);
        end
        out_ready = 1'b0;

        pin(8'h00, 8'h00, 10, 11, 10, 0);
        pin(8'h40, 8'h00, 20, 3, 1, 1);
        pin(8'h80, 8'h00, 20, 3, 1, 1);
        pin(8'hC0, 8'h00, 63, 64, 63, 0);
        pin(8'h00, 8'h00, 0, 1, 0, 0);

        run_pixel(8'h00, 8'h00, 10, 1, 0);
        run_pixel(8'h40, 8'h00, 20, 0, 0);
        run_pixel(8'h80, 8'h00, 20, 2, 0);
        run_pixel(8'hC0, 8'h00, 63, 0, 0);
        run_pixel(8'h00, 8'h00, 0, 5, 0);
        run_pixel(8'h00, 8'h00, 30, 0, 5);
        run_pixel(8'h00, 8'h00, 4, 0, 0);
        run_pixel(8'h40, 8'h00, 20, 1, 0);

        for (int p = 0; p < 40; p++) begin
            run_pixel(8'($urandom), 8'($urandom), int'($urandom_range(0, 63)),
                      int'($urandom_range(0, 3)), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
